// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, 8N1 frame constants and baud timing helper.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } rx_state_t;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  function automatic int unsigned symbol_edge_time(input int unsigned clock_freq,
                                                   input int unsigned baud_rate);
    return clock_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if: valid/ready byte stream from the receive queue to the MMIO logic.
interface uart_rx_buffered_if;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;

  modport master (
    output data_out,
    output data_out_valid,
    input  data_out_ready
  );

  modport slave (
    input  data_out,
    input  data_out_valid,
    output data_out_ready
  );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, DEPTH a power of two; push while full is accepted only with a pop.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             wr_en, rd_en;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign rd_en = pop && !empty;
  assign wr_en = push && (!full || rd_en);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_en) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage is cleared so the head reads 0x00 straight out of reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 8N1 UART receiver with mid-bit sampling feeding a receive queue.
// UART_RX_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single holding register.
module uart_rx_buffered
  import uart_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115_200,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          serial_in,
  uart_rx_buffered_if.master            rx_if,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_error,
  output logic                          overflow
);
  localparam int unsigned SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int unsigned SAMPLE_TIME      = SYMBOL_EDGE_TIME / 2;
  localparam int unsigned CNT_W            = $clog2(SYMBOL_EDGE_TIME + 1);
  localparam int unsigned IDX_W            = $clog2(DATA_BITS);
  localparam int unsigned FC_W             = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]           sync_q, sync_d;
  logic                 rx;
  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 frame_error_q, frame_error_d;
  logic                 overflow_q, overflow_d;
  logic                 half_pt, full_pt;
  logic                 push, pop, full;

  assign sync_d = {sync_q[0], serial_in};
  assign rx     = sync_q[1];

  assign half_pt = (cnt_q == CNT_W'(SAMPLE_TIME));
  assign full_pt = (cnt_q == CNT_W'(SYMBOL_EDGE_TIME - 1));

  // DATA and STOP are entered at the middle of the start bit, so each of their
  // samples lands one full symbol after entry / the previous sample: mid-bit.
  always_comb begin
    state_d       = state_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    frame_error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!rx) state_d = ST_START;
      end
      ST_START: begin
        if (half_pt) begin
          if (!rx) begin
            state_d   = ST_DATA;
            bit_idx_d = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_DATA: begin
        if (full_pt) begin
          shift_d = {rx, shift_q[DATA_BITS-1:1]};
          if (bit_idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
          end
        end
      end
      ST_STOP: begin
        if (full_pt) begin
          if (rx) push = 1'b1;
          else    frame_error_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) cnt_d = '0;
    else if (full_pt)       cnt_d = '0;
    else                    cnt_d = cnt_q + CNT_W'(1);
  end

  assign pop        = rx_if.data_out_valid && rx_if.data_out_ready;
  assign overflow_d = push && full && !pop;

`ifdef UART_RX_FIFO_EN
  logic fifo_empty;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (shift_q),
    .dout  (rx_if.data_out),
    .full  (full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign rx_if.data_out_valid = !fifo_empty;
`else
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] hold_data_q, hold_data_d;

  assign full = hold_valid_q;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (push && (!full || pop)) begin
      hold_valid_d = 1'b1;
      hold_data_d  = shift_q;
    end else if (pop) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign rx_if.data_out       = hold_data_q;
  assign rx_if.data_out_valid = hold_valid_q;
  assign fifo_count           = FC_W'(hold_valid_q);
`endif

  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '1;
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      frame_error_q <= frame_error_d;
      overflow_q    <= overflow_d;
    end
  end
endmodule
